// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the union-find decoding array: runs GROW/MERGE rounds
// until no cluster is odd. Optional cycle profiling is enabled by DECODER_CYCLE_PROFILE_EN.
module decoder_stage_controller #(
  parameter int PU_COUNT            = 8,
  parameter int MERGE_SETTLE_CYCLES = 3,
  parameter int MAX_MERGE_CYCLES    = 64,
  parameter int MAX_GROW            = 16,
  parameter int ITER_WIDTH          = 5,
  parameter int STAGE_WIDTH         = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic [PU_COUNT-1:0]    busy,
  input  logic [PU_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   grow_overflow,
  output logic                   merge_timeout,
  output logic [31:0]            cycle_count
);

  // Stage bus codes shared with the processing units.
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = STAGE_WIDTH'(4);

  localparam int MC_WIDTH = (MAX_MERGE_CYCLES > 1) ? $clog2(MAX_MERGE_CYCLES) : 1;
  localparam logic [MC_WIDTH-1:0]   SETTLE_K   = MC_WIDTH'(MERGE_SETTLE_CYCLES);
  localparam logic [MC_WIDTH-1:0]   LIMIT_K    = MC_WIDTH'(MAX_MERGE_CYCLES - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_GROW);
  localparam logic [ITER_WIDTH-1:0] ITER_SAT   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GROW,
    S_MERGE,
    S_DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [ITER_WIDTH-1:0]    iter_reg, iter_next;
  logic                     grow_ovf_reg, grow_ovf_next;
  logic                     merge_to_reg, merge_to_next;
  logic [MC_WIDTH-1:0]      merge_cnt_reg, merge_cnt_next;
  logic [STAGE_WIDTH-1:0]   stage_reg, stage_next;
  logic                     ready_reg, valid_reg;
  logic                     settle_done, at_limit, merge_exit;

  // busy is only trusted once the PU stage and busy registers have caught up.
  assign settle_done = (merge_cnt_reg >= SETTLE_K);
  assign at_limit    = (merge_cnt_reg == LIMIT_K);
  assign merge_exit  = settle_done && ((busy == '0) || at_limit);

  always_comb begin
    state_next     = state_reg;
    iter_next      = iter_reg;
    grow_ovf_next  = grow_ovf_reg;
    merge_to_next  = merge_to_reg;
    merge_cnt_next = merge_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next     = S_LOAD;
          iter_next      = '0;
          grow_ovf_next  = 1'b0;
          merge_to_next  = 1'b0;
          merge_cnt_next = '0;
        end
      end
      S_LOAD: state_next = S_GROW;
      S_GROW: begin
        if (iter_reg != ITER_SAT) iter_next = iter_reg + 1'b1;
        merge_cnt_next = '0;
        state_next     = S_MERGE;
      end
      S_MERGE: begin
        merge_cnt_next = merge_cnt_reg + 1'b1;
        if (merge_exit) begin
          if (at_limit && (busy != '0)) merge_to_next = 1'b1;
          if (odd == '0) begin
            state_next = S_DONE;
          end else if (iter_reg < ITER_LIMIT) begin
            state_next = S_GROW;
          end else begin
            state_next    = S_DONE;
            grow_ovf_next = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (result_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    case (state_next)
      S_LOAD:  stage_next = STAGE_MEASUREMENT_LOADING;
      S_GROW:  stage_next = STAGE_GROW;
      S_MERGE: stage_next = STAGE_MERGE;
      S_DONE:  stage_next = STAGE_RESULT_VALID;
      default: stage_next = STAGE_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      iter_reg      <= '0;
      grow_ovf_reg  <= 1'b0;
      merge_to_reg  <= 1'b0;
      merge_cnt_reg <= '0;
      stage_reg     <= STAGE_IDLE;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      iter_reg      <= iter_next;
      grow_ovf_reg  <= grow_ovf_next;
      merge_to_reg  <= merge_to_next;
      merge_cnt_reg <= merge_cnt_next;
      stage_reg     <= stage_next;
      ready_reg     <= (state_next == S_IDLE);
      valid_reg     <= (state_next == S_DONE);
    end
  end

  assign ready           = ready_reg;
  assign result_valid    = valid_reg;
  assign global_stage    = stage_reg;
  assign iteration_count = iter_reg;
  assign grow_overflow   = grow_ovf_reg;
  assign merge_timeout   = merge_to_reg;

`ifdef DECODER_CYCLE_PROFILE_EN
  logic [31:0] cycle_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_reg <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      cycle_count_reg <= '0;
    end else if ((state_reg inside {S_LOAD, S_GROW, S_MERGE}) && (cycle_count_reg != 32'hFFFF_FFFF)) begin
      cycle_count_reg <= cycle_count_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Self-checking bench for decoder_stage_controller: a cycle-level behavioural model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_decoder_stage_controller;
  localparam int PU = 4;
  localparam int SETTLE = 3;
  localparam int MAXM = 64;
  localparam int MAXG = 16;
  localparam int IW = 5;
  localparam int SW = 3;
  localparam int C_IDLE = 0, C_LOAD = 1, C_GROW = 2, C_MERGE = 3, C_RV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready;
  logic [PU-1:0] busy = '0;
  logic [PU-1:0] odd = '0;
  logic [SW-1:0] global_stage;
  logic result_valid;
  logic result_ready = 1'b1;
  logic [IW-1:0] iteration_count;
  logic grow_overflow;
  logic merge_timeout;
  logic [31:0] cycle_count;

  decoder_stage_controller #(
    .PU_COUNT(PU), .MERGE_SETTLE_CYCLES(SETTLE), .MAX_MERGE_CYCLES(MAXM),
    .MAX_GROW(MAXG), .ITER_WIDTH(IW), .STAGE_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy), .odd(odd),
    .global_stage(global_stage), .result_valid(result_valid), .result_ready(result_ready),
    .iteration_count(iteration_count), .grow_overflow(grow_overflow),
    .merge_timeout(merge_timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0..4 = idle, load, grow, merge, done; k = cycle within MERGE.
  int m_phase = 0, m_k = 0, m_iter = 0, m_ovf = 0, m_to = 0, m_cyc = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_k = 0; m_iter = 0; m_ovf = 0; m_to = 0; m_cyc = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_iter = 0; m_ovf = 0; m_to = 0; m_cyc = 0;
        end
        1: begin m_phase = 2; m_cyc++; end
        2: begin
          m_iter = (m_iter < 31) ? m_iter + 1 : 31;
          m_k = 0; m_phase = 3; m_cyc++;
        end
        3: begin
          m_cyc++;
          if (m_k >= SETTLE && (busy == 0 || m_k == MAXM - 1)) begin
            if (busy != 0) m_to = 1;
            if (odd == 0) m_phase = 4;
            else if (m_iter < MAXG) m_phase = 2;
            else begin m_phase = 4; m_ovf = 1; end
          end else begin
            m_k++;
          end
        end
        default: if (result_ready) m_phase = 0;
      endcase
    end
  end

  // Input policy: busy held for the first busy_cycles MERGE cycles, odd set for the first odd_rounds rounds.
  int busy_cycles = 0, odd_rounds = 0;
  logic [PU-1:0] busy_pat = '0, odd_pat = '0;

  always @(negedge clk) begin
    busy = (m_phase == 3 && m_k < busy_cycles) ? busy_pat : '0;
    odd  = (m_phase == 3 && m_iter <= odd_rounds) ? odd_pat : '0;
  end

  always @(negedge clk) begin
    check("model_stage", 32'(global_stage), 32'(m_phase));
    check("model_ready", 32'(ready), 32'(m_phase == 0));
    check("model_valid", 32'(result_valid), 32'(m_phase == 4));
    check("model_iter", 32'(iteration_count), 32'(m_iter));
    check("model_ovf", 32'(grow_overflow), 32'(m_ovf));
    check("model_timeout", 32'(merge_timeout), 32'(m_to));
`ifdef DECODER_CYCLE_PROFILE_EN
    check("model_cycles", cycle_count, 32'(m_cyc));
`else
    check("model_cycles", cycle_count, 32'd0);
`endif
  end

  task automatic run_decode(output int grows, output int merges);
    bit done_ok;
    grows = 0; merges = 0; done_ok = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (global_stage == SW'(C_GROW)) grows++;
      if (global_stage == SW'(C_MERGE)) merges++;
      if (result_valid) begin done_ok = 1; break; end
      @(negedge clk);
    end
    check("decode_reaches_done", 32'(done_ok), 32'd1);
    $display("decode: grows=%0d merges=%0d iter=%0d ovf=%0d timeout=%0d cycles=%0d",
             grows, merges, iteration_count, grow_overflow, merge_timeout, cycle_count);
  endtask

  task automatic wait_stage(input int code);
    bit found;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (global_stage == SW'(code)) begin found = 1; break; end
      @(negedge clk);
    end
    check("wait_stage", 32'(found), 32'd1);
  endtask

  int seq [7] = '{C_LOAD, C_GROW, C_MERGE, C_MERGE, C_MERGE, C_MERGE, C_RV};
  int g, m;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_stage", 32'(global_stage), C_IDLE);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(result_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // All-quiet decode, cycle-exact.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("quiet_seq", 32'(global_stage), 32'(seq[i]));
      if (i < 6) @(negedge clk);
    end
    check("quiet_valid", 32'(result_valid), 32'd1);
    check("quiet_iter", 32'(iteration_count), 32'd1);
    check("quiet_ovf", 32'(grow_overflow), 32'd0);
    check("quiet_to", 32'(merge_timeout), 32'd0);
`ifdef DECODER_CYCLE_PROFILE_EN
    check("quiet_cycles", cycle_count, 32'd6);
`endif
    $display("decode: all-quiet iter=%0d cycles=%0d", iteration_count, cycle_count);
    @(negedge clk);
    check("quiet_back_idle", 32'(ready), 32'd1);

    // Two rounds.
    odd_pat = 4'b0010; odd_rounds = 1;
    run_decode(g, m);
    check("two_grows", 32'(g), 32'd2);
    check("two_iter", 32'(iteration_count), 32'd2);
    check("two_ovf", 32'(grow_overflow), 32'd0);
    odd_rounds = 0;
    @(negedge clk);

    // Busy holds MERGE through k=9.
    busy_pat = 4'b0001; busy_cycles = 10;
    run_decode(g, m);
    check("busy_merges", 32'(m), 32'd11);
    check("busy_to", 32'(merge_timeout), 32'd0);
    @(negedge clk);

    // Busy stuck: merge timeout.
    busy_pat = 4'b1000; busy_cycles = 100000;
    run_decode(g, m);
    check("to_merges", 32'(m), 32'd64);
    check("to_flag", 32'(merge_timeout), 32'd1);
    busy_cycles = 0;
    @(negedge clk);
    check("to_flag_holds_idle", 32'(merge_timeout), 32'd1);

    // Odd stuck: grow overflow.
    odd_pat = 4'b0101; odd_rounds = 100;
    run_decode(g, m);
    check("ovf_grows", 32'(g), 32'd16);
    check("ovf_iter", 32'(iteration_count), 32'd16);
    check("ovf_flag", 32'(grow_overflow), 32'd1);
    check("ovf_to_cleared", 32'(merge_timeout), 32'd0);
    odd_rounds = 0;
    @(negedge clk);

    // Consumer stalls for 5 cycles.
    result_ready = 1'b0;
    run_decode(g, m);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(result_valid), 32'd1);
    end
    result_ready = 1'b1;
    @(negedge clk);
    check("stall_ready", 32'(ready), 32'd1);
    check("stall_valid_low", 32'(result_valid), 32'd0);
    check("stall_idle", 32'(global_stage), C_IDLE);

    // start during MERGE is ignored and not queued.
    busy_pat = 4'b0100; busy_cycles = 20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_stage(C_MERGE);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_start_ignored", 32'(global_stage), C_MERGE);
    wait_stage(C_RV);
    @(negedge clk);
    @(negedge clk);
    check("no_queued_start", 32'(global_stage), C_IDLE);
    $display("decode: start-during-merge iter=%0d", iteration_count);

    // Reset in MERGE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_stage(C_MERGE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_stage", 32'(global_stage), C_IDLE);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_iter", 32'(iteration_count), 32'd0);
    check("rst_cycles", cycle_count, 32'd0);
    reset = 1'b0;
    busy_cycles = 0;
    @(negedge clk);
    $display("decode: reset-in-merge stage=%0d ready=%0d", global_stage, ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decoder_stage_controller.md
# decoder_stage_controller

Global stage sequencer for the union-find decoding array. It accepts a decode request and drives the shared `global_stage` bus into every processing unit. It repeats GROW/MERGE rounds until no cluster is odd, or until the growth limit is reached, then presents the result under a valid/ready handshake. It is the direct upstream driver of the processing-unit array and consumes that array's `busy` and `odd` flags.

## Interface
Parameters:
- `PU_COUNT`, 8: number of processing units observed.
- `MERGE_SETTLE_CYCLES`, 3: initial MERGE cycles during which `busy` is ignored.
- `MAX_MERGE_CYCLES`, 64: MERGE length limit per round.
- `MAX_GROW`, 16: GROW-stage limit per decode.
- `ITER_WIDTH`, 5: width of `iteration_count`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  decode request; accepted when `start && ready`.
- `ready`  out  1  high only in IDLE.
- `busy`  in  PU_COUNT  per-PU busy flags.
- `odd`  in  PU_COUNT  per-PU odd flags.
- `global_stage`  out  STAGE_WIDTH  stage bus, using STAGE_* codes from the shared parameters include.
- `result_valid`  out  1  decode complete.
- `result_ready`  in  1  consumer acknowledge.
- `iteration_count`  out  ITER_WIDTH  number of GROW stages issued in this decode.
- `grow_overflow`  out  1  decode ended with odd clusters still present.
- `merge_timeout`  out  1  a MERGE stage hit `MAX_MERGE_CYCLES`.
- `cycle_count`  out  32  profile counter (see Configuration).

## Operation
- FSM states: IDLE, LOAD, GROW, MERGE, DONE.
- `global_stage` is registered and decoded from state:
  - IDLE→STAGE_IDLE
  - LOAD→STAGE_MEASUREMENT_LOADING
  - GROW→STAGE_GROW
  - MERGE→STAGE_MERGE
  - DONE→STAGE_RESULT_VALID
- IDLE: `ready`=1. On `start`, go to LOAD and clear `iteration_count`, `grow_overflow`, `merge_timeout` and the merge counter.
- LOAD: lasts exactly 1 cycle, then GROW.
- GROW: lasts exactly 1 cycle. Increment `iteration_count` (saturating), then go to MERGE with the merge counter set to 0.
- MERGE: the merge counter increments every cycle. Let k be the cycle index within MERGE.
  - For k < MERGE_SETTLE_CYCLES, `busy` is ignored.
  - Otherwise the stage exits when `busy`==0, or when k == MAX_MERGE_CYCLES−1. On the limit exit, set `merge_timeout` (sticky).
- Exit decision, using `odd` sampled in the exit cycle:
  - `|odd`==0 → DONE.
  - `|odd`==1 and `iteration_count` < MAX_GROW → GROW.
  - `|odd`==1 and `iteration_count` == MAX_GROW → DONE, with `grow_overflow`=1.
- DONE: `result_valid`=1, held until `result_ready`. Then go to IDLE. `iteration_count` and the flags hold their values until the next accepted `start`.
- `start` outside IDLE is ignored, and is not queued.

## Timing
- Reset values:
  - state IDLE, `global_stage`=STAGE_IDLE, `ready`=1.
  - `result_valid`=0, `iteration_count`=0, `grow_overflow`=0, `merge_timeout`=0, `cycle_count`=0.
- Reset asserted in any state aborts the decode. Reset has priority over `start` and `result_ready`.
- Handshake with `start` accepted at cycle T:
  - `global_stage`=LOAD at T+1.
  - GROW at T+2.
  - MERGE from T+3.
- Minimum MERGE length is MERGE_SETTLE_CYCLES+1. This covers the PU stage-register lag plus the `busy` register lag.
- Exit from MERGE at cycle E gives `global_stage` = GROW or DONE at E+1.
- `result_valid` rises in the same cycle that `global_stage`=STAGE_RESULT_VALID.
- `result_valid && result_ready` at cycle D gives `ready`=1 at D+1. A `start` at D is ignored.

## Configuration
- `DECODER_CYCLE_PROFILE_EN` defined:
  - `cycle_count` clears on `start` acceptance and increments every cycle outside IDLE and DONE.
  - It saturates at 2^32−1.
  - It holds through DONE until the next accepted `start`.
- Not defined: `cycle_count` is constant 0 and no counter logic is synthesized.

## Test plan
All scenarios use PU_COUNT=4, MERGE_SETTLE_CYCLES=3, MAX_MERGE_CYCLES=64, MAX_GROW=16.
- **All-quiet decode:** `start` at cycle 0 with `busy`=0 and `odd`=0 → LOAD c1, GROW c2, MERGE c3–c6, DONE c7 with `result_valid`=1, `iteration_count`=1, both flags 0, `cycle_count`=6 when the macro is defined.
- **Two rounds:** `odd`=4'b0010 at the first MERGE exit and 0 at the second → exactly two GROW cycles, `iteration_count`=2, DONE reached.
- **Busy holds MERGE:** `busy`=4'b0001 for MERGE cycles k=0..9 → exit at k=10, 11 MERGE cycles total.
- **Timeouts and overflow:**
  - `busy` stuck at 4'b1000 → `merge_timeout`=1 after 64 MERGE cycles.
  - `odd` stuck nonzero → DONE after 16 GROWs with `grow_overflow`=1.
- **Handshake and reset:**
  - `result_ready` held low for 5 cycles → `result_valid` held for 5 cycles, then IDLE one cycle after acceptance.
  - `start` during MERGE → ignored.
  - Reset in MERGE → next cycle IDLE with all outputs at their reset values.
